// File: rtl/branch_cmp_pkg.sv
// Shared definitions for the ID-stage branch resolver: branch compare opcodes,
// resolver state encodings and the operand-readiness helper.
package branch_cmp_pkg;

    localparam logic [2:0] CMP_BEQ  = 3'd0;
    localparam logic [2:0] CMP_BNE  = 3'd1;
    localparam logic [2:0] CMP_BLEZ = 3'd2;
    localparam logic [2:0] CMP_BGTZ = 3'd3;
    localparam logic [2:0] CMP_BLTZ = 3'd4;
    localparam logic [2:0] CMP_BGEZ = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Single-operand compares against zero ignore rt; unknown opcodes wait for both operands.
    function automatic logic operands_ready(input logic [2:0] op,
                                            input logic       rs_rdy,
                                            input logic       rt_rdy);
        logic rdy;
        case (op)
            CMP_BLEZ, CMP_BGTZ, CMP_BLTZ, CMP_BGEZ: rdy = rs_rdy;
            CMP_BEQ, CMP_BNE:                       rdy = rs_rdy & rt_rdy;
            default:                                rdy = rs_rdy & rt_rdy;
        endcase
        return rdy;
    endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Pure combinational branch condition evaluator: (cmp_op, rs, rt) -> taken.
// Zero-relative compares use the sign bit plus a zero test instead of a subtractor.
module branch_cmp_core
    import branch_cmp_pkg::*;
(
    input  logic [2:0]  cmp_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken
);

    logic rs_neg_s;
    logic rs_zero_s;

    assign rs_neg_s  = rs_data[31];
    assign rs_zero_s = (rs_data == 32'd0);

    // Branch condition decode; undefined opcodes never take.
    always_comb begin
        taken = 1'b0;
        case (cmp_op)
            CMP_BEQ:  taken = (rs_data == rt_data);
            CMP_BNE:  taken = (rs_data != rt_data);
            CMP_BLEZ: taken = rs_neg_s | rs_zero_s;
            CMP_BGTZ: taken = ~rs_neg_s & ~rs_zero_s;
            CMP_BLTZ: taken = rs_neg_s;
            CMP_BGEZ: taken = ~rs_neg_s;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cmp_unit.sv
// ID-stage branch resolver: stalls until operands are forwardable, registers the
// compare result and flags runaway stalls. Optional statistics: BRANCH_STATS_EN.
module branch_cmp_unit
    import branch_cmp_pkg::*;
#(
    parameter int unsigned MAX_STALL = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        cmp_op,
    input  logic [31:0]       rs_data,
    input  logic [31:0]       rt_data,
    input  logic              rs_ready,
    input  logic              rt_ready,
    output logic              id_stall,
    output logic              cmp_out,
    output logic              cmp_valid,
    output logic              stall_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  nottaken_cnt
`endif
);

    localparam int unsigned SC_W = $clog2(MAX_STALL + 1);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(MAX_STALL);

    if (MAX_STALL < 1 || CNT_W < 1) begin : g_param_check
        $error("branch_cmp_unit: MAX_STALL and CNT_W must be at least 1");
    end

    state_e          state_r;
    state_e          state_nxt_s;
    logic [SC_W-1:0] stall_cnt_r;
    logic [SC_W-1:0] stall_cnt_nxt_s;
    logic            cmp_out_r;
    logic            cmp_valid_r;
    logic            stall_err_r;
    logic            ready_s;
    logic            taken_s;
    logic            resolve_s;
    logic            stall_s;
    logic            err_set_s;

    branch_cmp_core u_core (
        .cmp_op  (cmp_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .taken   (taken_s)
    );

    assign ready_s = operands_ready(cmp_op, rs_ready, rt_ready);

    // Next-state, stall and stall-counter decode; flush wins over any resolve.
    always_comb begin
        state_nxt_s     = state_r;
        stall_cnt_nxt_s = stall_cnt_r;
        resolve_s       = 1'b0;
        stall_s         = 1'b0;
        if (!en) begin
            state_nxt_s     = state_r;
            stall_cnt_nxt_s = stall_cnt_r;
        end else if (flush) begin
            state_nxt_s     = ST_IDLE;
            stall_cnt_nxt_s = {SC_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (id_valid && ready_s) begin
                        resolve_s = 1'b1;
                    end else if (id_valid) begin
                        stall_s         = 1'b1;
                        state_nxt_s     = ST_WAIT;
                        stall_cnt_nxt_s = SC_W'(1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ready_s) begin
                        resolve_s       = 1'b1;
                        state_nxt_s     = ST_IDLE;
                        stall_cnt_nxt_s = {SC_W{1'b0}};
                    end else begin
                        stall_s = 1'b1;
                        if (stall_cnt_r >= STALL_MAX) begin
                            stall_cnt_nxt_s = STALL_MAX;
                        end else begin
                            stall_cnt_nxt_s = stall_cnt_r + SC_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    stall_cnt_nxt_s = {SC_W{1'b0}};
                end
            endcase
        end
    end

    assign err_set_s = stall_s && (stall_cnt_nxt_s == STALL_MAX);

    // Stall is masked while reset is held so it drops together with the state.
    assign id_stall  = stall_s & reset;
    assign cmp_out   = cmp_out_r;
    assign cmp_valid = cmp_valid_r;
    assign stall_err = stall_err_r;

    // Resolver state, result register, valid pulse and sticky stall error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            stall_cnt_r <= {SC_W{1'b0}};
            cmp_out_r   <= 1'b0;
            cmp_valid_r <= 1'b0;
            stall_err_r <= 1'b0;
        end else if (en) begin
            state_r     <= state_nxt_s;
            stall_cnt_r <= stall_cnt_nxt_s;
            cmp_valid_r <= resolve_s;
            if (resolve_s) begin
                cmp_out_r <= taken_s;
            end
            if (err_set_s) begin
                stall_err_r <= 1'b1;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_r;
    logic [CNT_W-1:0] nottaken_cnt_r;

    // Outcome counters advance only on latched results and wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt_r    <= {CNT_W{1'b0}};
            nottaken_cnt_r <= {CNT_W{1'b0}};
        end else if (en && resolve_s) begin
            if (taken_s) begin
                taken_cnt_r <= taken_cnt_r + CNT_W'(1);
            end else begin
                nottaken_cnt_r <= nottaken_cnt_r + CNT_W'(1);
            end
        end
    end

    assign taken_cnt    = taken_cnt_r;
    assign nottaken_cnt = nottaken_cnt_r;
`endif

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Self-checking bench for branch_cmp_unit: directed scenarios then random traffic
// against a pending-branch reference model. Stats checks need BRANCH_STATS_EN.
module tb_branch_cmp_unit;

    localparam int MAX_STALL = 8;
    localparam int CNT_W     = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b1;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [2:0]  cmp_op = 3'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        rs_ready = 1'b0;
    logic        rt_ready = 1'b0;
    logic        id_stall;
    logic        cmp_out;
    logic        cmp_valid;
    logic        stall_err;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] nottaken_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: is a branch waiting, how long has it stalled, last outputs.
    bit m_pending;
    int m_stalls;
    bit m_out, m_valid, m_err;
    int m_taken_n, m_nottaken_n;
    int obs_stalls;

    branch_cmp_unit #(.MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .id_valid  (id_valid),
        .cmp_op    (cmp_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .rs_ready  (rs_ready),
        .rt_ready  (rt_ready),
        .id_stall  (id_stall),
        .cmp_out   (cmp_out),
        .cmp_valid (cmp_valid),
        .stall_err (stall_err)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int signed srs;
        srs = $signed(rs);
        case (op)
            3'd0: return rs == rt;
            3'd1: return rs != rt;
            3'd2: return srs <= 0;
            3'd3: return srs > 0;
            3'd4: return srs < 0;
            3'd5: return srs >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_ready(input logic [2:0] op, input logic rsr, input logic rtr);
        if (op >= 3'd2 && op <= 3'd5) return rsr;
        return rsr && rtr;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic rsr, input logic rtr);
        id_valid = v; cmp_op = op; rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr;
    endtask

    task automatic model_reset();
        m_pending = 1'b0; m_stalls = 0; m_out = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        m_taken_n = 0; m_nottaken_n = 0;
    endtask

    // One clock: check combinational stall, advance model, check registered outputs.
    task automatic cyc();
        bit rdy, exp_stall;
        #1;
        rdy = ref_ready(cmp_op, rs_ready, rt_ready);
        exp_stall = en && !flush && (m_pending || id_valid) && !rdy;
        chk("id_stall", {31'd0, id_stall}, {31'd0, exp_stall});
        if (id_stall === 1'b1) obs_stalls++;
        if (en) begin
            if (flush) begin
                m_pending = 1'b0; m_stalls = 0; m_valid = 1'b0;
            end else if (m_pending || id_valid) begin
                if (rdy) begin
                    m_out = ref_taken(cmp_op, rs_data, rt_data);
                    m_valid = 1'b1; m_pending = 1'b0; m_stalls = 0;
                    if (m_out) m_taken_n++; else m_nottaken_n++;
                end else begin
                    m_pending = 1'b1; m_valid = 1'b0;
                    if (m_stalls < MAX_STALL) m_stalls++;
                    if (m_stalls >= MAX_STALL) m_err = 1'b1;
                end
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("cmp_out", {31'd0, cmp_out}, {31'd0, m_out});
        chk("cmp_valid", {31'd0, cmp_valid}, {31'd0, m_valid});
        chk("stall_err", {31'd0, stall_err}, {31'd0, m_err});
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, m_taken_n);
        chk("nottaken_cnt", nottaken_cnt, m_nottaken_n);
`endif
    endtask

    // Asynchronous reset pulse away from the clock edge, released on a falling edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_id_stall", {31'd0, id_stall}, 32'd0);
        chk("rst_cmp_out", {31'd0, cmp_out}, 32'd0);
        chk("rst_cmp_valid", {31'd0, cmp_valid}, 32'd0);
        chk("rst_stall_err", {31'd0, stall_err}, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        en = 1'b1; flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        model_reset();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // BEQ both ready: one-cycle latency, never stalls.
        obs_stalls = 0;
        drive(1'b1, 3'd0, 32'h1234, 32'h1234, 1'b1, 1'b1);
        cyc();
        chk("beq_taken", {31'd0, cmp_out}, 32'd1);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();
        chk("beq_no_stall", obs_stalls, 32'd0);

        // Back-to-back zero-relative compares keep cmp_valid high.
        drive(1'b1, 3'd3, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("bgtz_neg", {31'd0, cmp_out}, 32'd0);
        drive(1'b1, 3'd5, 32'd0, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("bgez_zero", {31'd0, cmp_out}, 32'd1);
        drive(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
        cyc();
        chk("bltz_m1", {31'd0, cmp_out}, 32'd1);
        chk("b2b_valid", {31'd0, cmp_valid}, 32'd1);

        // BNE with rt late by 3 cycles: exactly 3 stall cycles.
        obs_stalls = 0;
        drive(1'b1, 3'd1, 32'd1, 32'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        rt_ready = 1'b1;
        cyc();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("bne_stalls", obs_stalls, 32'd3);
        chk("bne_taken", {31'd0, cmp_out}, 32'd1);

        // Runaway stall: error after the 8th stall cycle, sticky until reset.
        drive(1'b1, 3'd2, 32'd5, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 6) chk("err_before_max", {31'd0, stall_err}, 32'd0);
            if (i == 7) chk("err_at_max", {31'd0, stall_err}, 32'd1);
        end
        rs_ready = 1'b1;
        cyc();
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();
        chk("err_sticky", {31'd0, stall_err}, 32'd1);
        do_reset();

        // Flush in WAIT: no valid, cmp_out retains prior result.
        drive(1'b1, 3'd0, 32'd7, 32'd7, 1'b1, 1'b1);
        cyc();
        drive(1'b1, 3'd1, 32'd7, 32'd7, 1'b0, 1'b1);
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("flush_keep_out", {31'd0, cmp_out}, 32'd1);
        chk("flush_no_valid", {31'd0, cmp_valid}, 32'd0);
        cyc();

        // en low mid-WAIT freezes everything even though operands became ready.
        drive(1'b1, 3'd5, 32'h8000_0001, 32'd0, 1'b0, 1'b0);
        cyc();
        en = 1'b0;
        rs_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("en_frozen_out", {31'd0, cmp_out}, 32'd1);
        en = 1'b1;
        cyc();
        chk("en_resume_out", {31'd0, cmp_out}, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();

        // Reset while waiting drops id_stall asynchronously with branch still presented.
        drive(1'b1, 3'd0, 32'd1, 32'd1, 1'b1, 1'b0);
        cyc();
        cyc();
        do_reset();

        // Outcome statistics: 5 taken, 3 not taken, 1 flushed.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd0, 32'd9, (i < 5) ? 32'd9 : 32'd3, 1'b1, 1'b1);
            cyc();
        end
        drive(1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();
        chk("stats_taken_model", m_taken_n, 32'd5);
        chk("stats_nottaken_model", m_nottaken_n, 32'd3);
`ifdef BRANCH_STATS_EN
        chk("stats_taken", taken_cnt, 32'd5);
        chk("stats_nottaken", nottaken_cnt, 32'd3);
`endif

        // Random traffic; id_valid and operands stay stable while a branch is pending.
        for (int i = 0; i < 1500; i++) begin
            if (!m_pending) begin
                id_valid = ($urandom_range(0, 3) != 0);
                cmp_op   = 3'($urandom_range(0, 7));
                rs_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                rt_data  = ($urandom_range(0, 2) == 0) ? rs_data : $urandom;
            end
            rs_ready = ($urandom_range(0, 3) != 0);
            rt_ready = ($urandom_range(0, 3) != 0);
            en       = ($urandom_range(0, 9) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            cyc();
        end
        en = 1'b1;
        flush = 1'b0;
        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
